// File: rtl/fle_cfg_pkg.sv
// Fracturable LUT / FF-bank configuration layout.
// Bit offsets into the internal config chain.
package fle_cfg_pkg;

  function automatic int cfg_bits(input int k, input int n);
    return (1 << k) + 1 + 3 * n;
  endfunction

  function automatic int tt_lsb();
    return 0;
  endfunction

  function automatic int frac_bit(input int k);
    return 1 << k;
  endfunction

  function automatic int osel(input int k, input int j);
    return (1 << k) + 1 + 3 * j;
  endfunction

  function automatic int dsel(input int k, input int j);
    return (1 << k) + 2 + 3 * j;
  endfunction

  function automatic int ceuse(input int k, input int j);
    return (1 << k) + 3 + 3 * j;
  endfunction

endpackage

// File: rtl/fle_ff_slice.sv
// One output slice: D-select, scan, clock enable,
// flip-flop and registered/bypass output mux.
module fle_ff_slice (
  input  logic clk,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic test_en_i,
  input  logic scan_i,
  input  logic chain_i,
  input  logic lut_i,
  input  logic ce_i,
  input  logic ce_use_i,
  input  logic d_sel_i,
  input  logic out_sel_i,
  input  logic live_i,
  output logic q_o,
  output logic out_o
);

  logic q_q, q_d;

  // Next state: clear wins, then scan, then gated D.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 1'b0;
    end else if (test_en_i) begin
      q_d = scan_i;
    end else if (!ce_use_i || ce_i) begin
      q_d = d_sel_i ? chain_i : lut_i;
    end
  end

  // Slice flip-flop with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n_i) q_q <= 1'b0;
    else          q_q <= q_d;
  end

  assign q_o   = q_q;
  assign out_o = live_i & (out_sel_i ? q_q : lut_i);

endmodule

// File: rtl/fle_frac_lut_ffbank.sv
// Fracturable K-LUT feeding NUM_OUT FF slices,
// with an internal config chain and done counter.
module fle_frac_lut_ffbank
  import fle_cfg_pkg::*;
#(
  parameter int LUT_K   = 4,
  parameter int NUM_OUT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Test_en,
  input  logic               ccff_en,
  input  logic               ccff_head,
  output logic               ccff_tail,
  output logic               cfg_done,
  input  logic [LUT_K-1:0]   fabric_in,
  input  logic               fabric_regin,
  input  logic               fabric_scin,
  input  logic               fabric_ce,
  output logic [NUM_OUT-1:0] fabric_out,
  output logic               fabric_regout,
  output logic               fabric_scout
);

  localparam int CFG_BITS = cfg_bits(LUT_K, NUM_OUT);
  localparam int TT       = 1 << LUT_K;
  localparam int HALF     = TT / 2;
  localparam int CW       = $clog2(CFG_BITS + 1);
  localparam int TT0      = tt_lsb();
  localparam int FRB      = frac_bit(LUT_K);
  localparam logic [CW-1:0] CNT_MAX = CW'(CFG_BITS);

  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;

  // Config shift, bit counter and restart on a new shift.
  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    if (ccff_en) begin
      cfg_d = {cfg_q[CFG_BITS-2:0], ccff_head};
      if (done_q)               cnt_d = CW'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
    done_d = (cnt_d == CNT_MAX);
  end

  // Config state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign ccff_tail = cfg_q[CFG_BITS-1];
  assign cfg_done  = done_q;

  logic [TT-1:0]    tt;
  logic [HALF-1:0]  tt_lo, tt_hi;
  logic [LUT_K-2:0] idx;
  logic             frac;
  logic             lut_full, lut_lo, lut_hi;

  assign tt       = cfg_q[TT0 +: TT];
  assign tt_lo    = tt[HALF-1:0];
  assign tt_hi    = tt[TT-1:HALF];
  assign frac     = cfg_q[FRB];
  assign idx      = fabric_in[LUT_K-2:0];
  assign lut_full = tt[fabric_in];
  assign lut_lo   = tt_lo[idx];
  assign lut_hi   = tt_hi[idx];

  // FFs are held clear until configured and on restart.
  logic clr;
  assign clr = ~done_q | ccff_en;

  logic [NUM_OUT-1:0] ff_q;
  logic [NUM_OUT-1:0] lut_out;

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_slice
    localparam int OS = osel(LUT_K, j);
    localparam int DS = dsel(LUT_K, j);
    localparam int CU = ceuse(LUT_K, j);

    logic half_sel;
    logic prev;

    if (j % 2 == 1) begin : g_odd
      assign half_sel = lut_hi;
    end else begin : g_even
      assign half_sel = lut_lo;
    end

    if (j == 0) begin : g_first
      assign prev = 1'b0;
    end else begin : g_rest
      assign prev = ff_q[j-1];
    end

    assign lut_out[j] = frac ? half_sel : lut_full;

    fle_ff_slice u_slice (
      .clk       (clk),
      .rst_n_i   (rst_n),
      .clr_i     (clr),
      .test_en_i (Test_en),
      .scan_i    (j == 0 ? fabric_scin : prev),
      .chain_i   (j == 0 ? fabric_regin : prev),
      .lut_i     (lut_out[j]),
      .ce_i      (fabric_ce),
      .ce_use_i  (cfg_q[CU]),
      .d_sel_i   (cfg_q[DS]),
      .out_sel_i (cfg_q[OS]),
      .live_i    (done_q),
      .q_o       (ff_q[j]),
      .out_o     (fabric_out[j])
    );
  end

  assign fabric_regout = ff_q[NUM_OUT-1];
  assign fabric_scout  = ff_q[NUM_OUT-1];

endmodule

// File: tb/tb_fle_frac_lut_ffbank.sv
// Directed bench for the fracturable LUT / FF bank
// at default parameters (K=4, NUM_OUT=2, 23 cfg bits).
module tb_fle_frac_lut_ffbank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Test_en;
  logic       ccff_en;
  logic       ccff_head;
  logic       ccff_tail;
  logic       cfg_done;
  logic [3:0] fabric_in;
  logic       fabric_regin;
  logic       fabric_scin;
  logic       fabric_ce;
  logic [1:0] fabric_out;
  logic       fabric_regout;
  logic       fabric_scout;

  int nchk = 0;
  int nerr = 0;

  fle_frac_lut_ffbank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Test_en       (Test_en),
    .ccff_en       (ccff_en),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .cfg_done      (cfg_done),
    .fabric_in     (fabric_in),
    .fabric_regin  (fabric_regin),
    .fabric_scin   (fabric_scin),
    .fabric_ce     (fabric_ce),
    .fabric_out    (fabric_out),
    .fabric_regout (fabric_regout),
    .fabric_scout  (fabric_scout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [22:0] mk(
    input logic [15:0] tt,
    input logic        fr,
    input logic [1:0]  os,
    input logic [1:0]  ds,
    input logic [1:0]  cu
  );
    return {cu[1], ds[1], os[1],
            cu[0], ds[0], os[0], fr, tt};
  endfunction

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift w[n-1:0] MSB first; cfg_done must rise
  // exactly after edge number done_at (0 = never).
  task automatic shift(input logic [22:0] w,
                       input int n,
                       input int done_at);
    for (int k = 1; k <= n; k++) begin
      ccff_head = w[n-k];
      ccff_en   = 1'b1;
      step();
      chk("cfg_done_edge", {3'b0, cfg_done},
          {3'b0, k == done_at});
    end
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  logic [22:0] w7;

  initial begin
    rst_n        = 1'b0;
    Test_en      = 1'b0;
    ccff_en      = 1'b0;
    ccff_head    = 1'b0;
    fabric_in    = 4'h0;
    fabric_regin = 1'b0;
    fabric_scin  = 1'b0;
    fabric_ce    = 1'b0;

    // 1: reset with random inputs
    repeat (2) begin
      fabric_in    = 4'($urandom);
      fabric_regin = 1'($urandom);
      fabric_scin  = 1'($urandom);
      fabric_ce    = 1'($urandom);
      Test_en      = 1'($urandom);
      ccff_en      = 1'($urandom);
      ccff_head    = 1'($urandom);
      step();
    end
    chk("rst_out", {2'b0, fabric_out}, 4'h0);
    chk("rst_done", {3'b0, cfg_done}, 4'h0);
    chk("rst_tail", {3'b0, ccff_tail}, 4'h0);
    chk("rst_regout", {3'b0, fabric_regout}, 4'h0);
    chk("rst_scout", {3'b0, fabric_scout}, 4'h0);
    Test_en = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0;
    fabric_regin = 1'b0; fabric_scin = 1'b0;
    fabric_ce = 1'b0;
    rst_n = 1'b1;
    step();

    // 2: AND4 in full mode, bypass outputs
    shift(mk(16'h8000, 1'b0, 2'b00, 2'b00, 2'b00), 23, 23);
    fabric_in = 4'hF; #1;
    chk("and4_F", {2'b0, fabric_out}, 4'h3);
    fabric_in = 4'hE; #1;
    chk("and4_E", {2'b0, fabric_out}, 4'h0);
    chk("tail_t2", {3'b0, ccff_tail}, 4'h0);

    // 3: split LUT, lo=0x88 hi=0xEE
    shift(mk(16'hEE88, 1'b1, 2'b00, 2'b00, 2'b00), 23, 23);
    fabric_in = 4'b0001; #1;
    chk("frac_1", {2'b0, fabric_out}, 4'h2);
    fabric_in = 4'b0011; #1;
    chk("frac_3", {2'b0, fabric_out}, 4'h3);
    fabric_in = 4'b1000; #1;
    chk("frac_8", {2'b0, fabric_out}, 4'h0);

    // 4: registered outputs with clock enable
    shift(mk(16'h8000, 1'b0, 2'b11, 2'b00, 2'b11), 23, 23);
    chk("tail_t4", {3'b0, ccff_tail}, 4'h1);
    fabric_ce = 1'b1;
    fabric_in = 4'hF; #1;
    chk("reg_pre", {2'b0, fabric_out}, 4'h0);
    step();
    chk("reg_F", {2'b0, fabric_out}, 4'h3);
    fabric_in = 4'hE;
    step();
    chk("reg_E", {2'b0, fabric_out}, 4'h0);
    fabric_ce = 1'b0; fabric_in = 4'hF;
    step();
    chk("ce_hold0", {2'b0, fabric_out}, 4'h0);
    fabric_ce = 1'b1;
    step();
    chk("ce_load", {2'b0, fabric_out}, 4'h3);
    fabric_ce = 1'b0; fabric_in = 4'hE;
    step();
    chk("ce_hold1", {2'b0, fabric_out}, 4'h3);

    // 5: register chain, then scan ignoring CE
    shift(mk(16'h8000, 1'b0, 2'b11, 2'b11, 2'b11), 23, 23);
    fabric_ce = 1'b1;
    fabric_regin = 1'b1; step();
    chk("chain_e1", {3'b0, fabric_regout}, 4'h0);
    fabric_regin = 1'b0; step();
    chk("chain_e2", {3'b0, fabric_regout}, 4'h1);
    fabric_regin = 1'b1; step();
    chk("chain_e3", {3'b0, fabric_regout}, 4'h0);
    fabric_regin = 1'b0; step();
    chk("chain_e4", {3'b0, fabric_regout}, 4'h1);
    chk("chain_out", {2'b0, fabric_out}, 4'h2);
    Test_en = 1'b1; fabric_ce = 1'b0;
    fabric_scin = 1'b1; step();
    chk("scan_e1", {3'b0, fabric_scout}, 4'h0);
    step();
    chk("scan_e2", {3'b0, fabric_scout}, 4'h1);
    fabric_scin = 1'b0; step();
    chk("scan_e3", {3'b0, fabric_scout}, 4'h1);
    step();
    chk("scan_e4", {3'b0, fabric_scout}, 4'h0);
    Test_en = 1'b0;

    // 6: reset mid-shift clears cfg and counter
    shift(23'h7FFFFF, 10, 0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_done", {3'b0, cfg_done}, 4'h0);
    chk("midrst_tail", {3'b0, ccff_tail}, 4'h0);
    shift(23'h0, 13, 0);
    chk("cfg_cleared", {3'b0, ccff_tail}, 4'h0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    shift(mk(16'h8000, 1'b0, 2'b11, 2'b00, 2'b00), 23, 23);
    fabric_in = 4'hF;
    step();
    chk("t6_reg", {2'b0, fabric_out}, 4'h3);
    w7 = mk(16'h8000, 1'b0, 2'b00, 2'b00, 2'b00);
    ccff_head = w7[22]; ccff_en = 1'b1;
    step();
    ccff_en = 1'b0;
    chk("restart_done", {3'b0, cfg_done}, 4'h0);
    chk("restart_out", {2'b0, fabric_out}, 4'h0);
    chk("restart_ff", {3'b0, fabric_regout}, 4'h0);
    shift(w7, 22, 22);
    chk("restart_ff2", {3'b0, fabric_regout}, 4'h0);
    #1;
    chk("restart_byp", {2'b0, fabric_out}, 4'h3);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
